// File: rtl/eval_layer_scheduler_if.sv
// Event-queue handshake between the event queue (master) and the layer scheduler (slave).
interface eval_layer_scheduler_if #(
  parameter int NUM_INPUTS = 1
);
  logic                  q_valid;
  logic [NUM_INPUTS-1:0] q_mask;
  logic                  q_pop;

  modport master (output q_valid, output q_mask, input q_pop);
  modport slave  (input q_valid, input q_mask, output q_pop);
endinterface

// File: rtl/eval_layer_scheduler.sv
// Pops events one at a time and walks an evaluation token through the layered pipeline,
// keeping at least MIN_GAP cycles between issues.
//
// state | meaning
// IDLE  | ready to pop the next event when the queue is non-empty
// GAP   | waiting out the minimum issue gap after a pop
module eval_layer_scheduler #(
  parameter int NUM_INPUTS = 1,
  parameter int NUM_LAYERS = 12,
  parameter int MIN_GAP    = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  flush,
  eval_layer_scheduler_if.slave q,
  output logic [NUM_INPUTS-1:0] enable_in,
  output logic [NUM_LAYERS-1:0] layer_en,
  output logic                  done,
  output logic                  busy,
  output logic [CNT_W-1:0]      issued_cnt,
  output logic [CNT_W-1:0]      completed_cnt
);

  typedef enum logic [0:0] {IDLE, GAP} state_t;

  localparam logic [7:0] GAP_LOAD = (MIN_GAP > 1) ? 8'(MIN_GAP - 2) : 8'd0;

  state_t                state;
  logic [7:0]            gap_cnt;
  logic [NUM_INPUTS-1:0] mask_q;
  logic [NUM_LAYERS-1:0] layer_q;
  logic                  done_q;
  logic                  pop;

  assign pop       = en & ~rst & ~flush & q.q_valid & (state == IDLE);
  assign q.q_pop   = pop;

  // Registered strobes are held while en=0 but must not be seen downstream.
  assign layer_en  = en ? layer_q : '0;
  assign enable_in = (en & layer_q[0]) ? mask_q : '0;
  assign done      = en & done_q;
  assign busy      = (state != IDLE) | (|layer_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      gap_cnt       <= 8'd0;
      mask_q        <= '0;
      layer_q       <= '0;
      done_q        <= 1'b0;
      issued_cnt    <= '0;
      completed_cnt <= '0;
    end else if (en) begin
      // A done visible this cycle counts even if a flush lands on the same edge.
      if (done_q) completed_cnt <= completed_cnt + 1'b1;
      if (flush) begin
        state   <= IDLE;
        gap_cnt <= 8'd0;
        layer_q <= '0;
        done_q  <= 1'b0;
      end else begin
        layer_q <= (layer_q << 1) | NUM_LAYERS'(pop);
        done_q  <= layer_q[NUM_LAYERS-1];
        case (state)
          IDLE: begin
            if (pop) begin
              mask_q     <= q.q_mask;
              issued_cnt <= issued_cnt + 1'b1;
              if (MIN_GAP > 1) begin
                state   <= GAP;
                gap_cnt <= GAP_LOAD;
              end
            end
          end
          GAP: begin
            if (gap_cnt == 8'd0) state <= IDLE;
            else gap_cnt <= gap_cnt - 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
